alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_pkg.sv | 6 +
 rtl/alu_core.sv | 21 ++
 rtl/alu_share_arb.sv | 86 ++++++++
 tb/tb_alu_share_arb.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// alu_share_pkg: op encoding, FSM states and width default shared by the ALU arbiter
package alu_share_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_ADD = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational AND/OR/XOR/ADD with carry-out for ADD only
module alu_core
  import alu_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  logic [WIDTH:0] sum;
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b : sum[WIDTH-1:0];
    carry  = op == OP_ADD ? sum[WIDTH] : 1'b0;
  end
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbitration of two requesters onto one shared ALU
module alu_share_arb
  import alu_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy
);
  state_e           state, state_nx;
  logic [1:0]       rst_sync;
  logic             rst_i_n;
  logic             ptr, win1, id_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, alu_res;
  logic             alu_c;
  // reset asserts asynchronously but releases only after two clean clk edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];
  // ptr == 0 gives requester 0 priority on a tie
  assign win1 = req1 & (~req0 | ptr);
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? ((req0 | req1) ? EXEC : IDLE) :
               state == EXEC ? RESP :
               state == RESP ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      ptr    <= 1'b0;
      id_q   <= 1'b0;
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      rsp_id <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      gnt0 <= state == IDLE && req0 && !win1;
      gnt1 <= state == IDLE && win1;
      if (state == IDLE && (req0 | req1)) begin
        ptr  <= ~win1;
        id_q <= win1;
        op_q <= op_e'(win1 ? op1 : op0);
        a_q  <= win1 ? a1 : a0;
        b_q  <= win1 ? b1 : b0;
      end
      if (state == EXEC) begin
        result <= alu_res;
        carry  <= alu_c;
        rsp_id <= id_q;
      end
    end
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .result(alu_res),
    .carry (alu_c)
  );
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector table plus hand-written arbitration and reset sequences
module tb_alu_share_arb;
  logic       clk = 1'b0;
  logic       rst_n, req0, req1, rsp_ready;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1, result;
  logic       gnt0, gnt1, rsp_valid, rsp_id, carry, busy;
  int         n_cmp = 0, n_bad = 0;
  typedef struct {
    bit         id;
    logic [1:0] op;
    logic [7:0] a, b, res;
    logic       c;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  alu_share_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .result(result), .carry(carry), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic set_req(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask
  initial begin
    int ngr;
    bit seq[4];
    rst_n = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 1'b1;
    vecs[0] = '{0, 2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{1, 2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    vecs[2] = '{0, 2'b10, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[3] = '{1, 2'b11, 8'hFF, 8'h02, 8'h01, 1'b1};
    vecs[4] = '{0, 2'b11, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{1, 2'b11, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[6] = '{0, 2'b00, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[7] = '{1, 2'b10, 8'h5A, 8'h5A, 8'h00, 1'b0};
    #2;
    chk("reset_outputs", {gnt0, gnt1, rsp_valid, busy, rsp_id, carry, result}, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", {busy, rsp_valid}, 0);
    // tie straight after reset: requester 0 first, then requester 1
    set_req(0, 2'b00, 8'h12, 8'h34);
    set_req(1, 2'b11, 8'hFF, 8'h02);
    tick();
    chk("tie_gnt", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("tie_rsp0", {rsp_valid, rsp_id, carry, result}, {3'b100, 8'h10});
    chk("tie_no_gnt_busy", {gnt0, gnt1}, 0);
    tick();
    chk("tie_idle", {rsp_valid, busy, gnt1}, 0);
    tick();
    chk("tie_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tick();
    chk("tie_rsp1", {rsp_valid, rsp_id, carry, result}, {3'b111, 8'h01});
    tick();
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk($sformatf("v%0d_gnt", i), {gnt0, gnt1, busy}, {~vecs[i].id, vecs[i].id, 1'b1});
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk($sformatf("v%0d_rsp", i), {rsp_valid, rsp_id, carry, result},
          {1'b1, vecs[i].id, vecs[i].c, vecs[i].res});
      tick();
      chk($sformatf("v%0d_one_cycle", i), {rsp_valid, busy}, 0);
    end
    // consumer stalls five cycles
    rsp_ready = 1'b0;
    set_req(0, 2'b10, 8'hAA, 8'hFF);
    tick();
    req0 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_%0d", i), {rsp_valid, busy, carry, result}, {3'b110, 8'h55});
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release", {rsp_valid, busy}, 0);
    // request raised during EXEC waits for IDLE
    set_req(0, 2'b01, 8'h01, 8'h02);
    tick();
    chk("late_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    set_req(1, 2'b11, 8'h01, 8'h01);
    tick();
    chk("late_resp_no_gnt1", {gnt1, rsp_valid, result}, {2'b01, 8'h03});
    tick();
    chk("late_idle_no_gnt1", {gnt1, busy}, 0);
    tick();
    chk("late_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tick();
    chk("late_rsp1", {rsp_valid, rsp_id, carry, result}, {3'b110, 8'h02});
    ngr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ngr += int'(gnt0) + int'(gnt1) + int'(rsp_valid);
    end
    chk("late_single_response", ngr, 0);
    // reset during EXEC
    set_req(0, 2'b00, 8'hFF, 8'hFF);
    tick();
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {gnt0, gnt1, rsp_valid, busy, rsp_id, carry, result}, 0);
    tick();
    rst_n = 1'b1;
    ngr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ngr += int'(rsp_valid) + int'(busy);
    end
    chk("midreset_no_resp", ngr, 0);
    set_req(0, 2'b01, 8'h0F, 8'hF0);
    tick();
    chk("postreset_gnt0", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("postreset_rsp", {rsp_valid, rsp_id, carry, result}, {3'b100, 8'hFF});
    tick();
    // both held continuously: grants alternate from requester 0
    do_reset();
    set_req(0, 2'b00, 8'hFF, 8'h0F);
    set_req(1, 2'b01, 8'h00, 8'h0F);
    ngr = 0;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      tick();
      if (gnt0 && gnt1) chk("rr_coincide", {gnt0, gnt1}, 2'b10);
      if (gnt0 || gnt1) begin
        seq[ngr] = gnt1;
        ngr++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", ngr, 4);
    chk("rr_order", {seq[0], seq[1], seq[2], seq[3]}, 4'b0101);
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
